// File: rtl/round_controller.sv
`default_nettype none
// ============================================================================
//  Module      : round_controller
//  Description : Game-round sequencer driven by the coarse timer tick. Arms
//                the timer, runs a fixed-length round of timer ticks, counts
//                player hits, holds a game-over period and tracks the best
//                score since reset.
//  Revision    : 1.0  initial release
// ============================================================================
module round_controller #(
    parameter int SCORE_W         = 8,
    parameter int TICKS_PER_ROUND = 6,
    parameter int OVER_HOLD_TICKS = 2,
    parameter int TL_W            = $clog2(TICKS_PER_ROUND + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               hit,
    input  logic               timer_tick,
    output logic               timer_enable,
    output logic               playing,
    output logic               game_over,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic               new_high,
    output logic [TL_W-1:0]    ticks_left
);

    localparam int HOLD_W = $clog2(OVER_HOLD_TICKS + 1);

    // All four encodings are used, so no state can lock the sequencer up.
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_READY = 2'd1;
    localparam logic [1:0] c_ST_PLAY  = 2'd2;
    localparam logic [1:0] c_ST_OVER  = 2'd3;

    localparam logic [SCORE_W-1:0] c_SCORE_MAX  = {SCORE_W{1'b1}};
    localparam logic [TL_W-1:0]    c_TICKS_INIT = TL_W'(TICKS_PER_ROUND);
    localparam logic [HOLD_W-1:0]  c_HOLD_LAST  = HOLD_W'(OVER_HOLD_TICKS - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nx;
    logic               r_start_q;
    logic               r_hit_q;
    logic               r_tick_q;
    logic [HOLD_W-1:0]  r_hold;
    logic [HOLD_W-1:0]  w_hold_nx;
    logic [SCORE_W-1:0] w_score_nx;
    logic [SCORE_W-1:0] w_high_nx;
    logic               w_new_high_nx;
    logic [TL_W-1:0]    w_ticks_nx;
    logic               w_start_rise;
    logic               w_hit_rise;
    logic               w_tick_rise;

    assign w_start_rise = start      & ~r_start_q;
    assign w_hit_rise   = hit        & ~r_hit_q;
    assign w_tick_rise  = timer_tick & ~r_tick_q;

    // Next-state and next-output decode; every target gets a hold default first.
    always_comb begin
        w_state_nx    = r_state;
        w_hold_nx     = r_hold;
        w_score_nx    = score;
        w_high_nx     = high_score;
        w_new_high_nx = 1'b0;
        w_ticks_nx    = ticks_left;
        case (r_state)
            c_ST_IDLE: begin
                w_ticks_nx = '0;
                if (w_start_rise) begin
                    w_state_nx = c_ST_READY;
                    w_score_nx = '0;
                end
            end
            c_ST_READY: begin
                w_ticks_nx = '0;
                if (w_tick_rise) begin
                    w_state_nx = c_ST_PLAY;
                    w_ticks_nx = c_TICKS_INIT;
                end
            end
            c_ST_PLAY: begin
                // Hit is applied first so a hit on the final tick still counts.
                if (w_hit_rise && (score != c_SCORE_MAX)) begin
                    w_score_nx = score + 1'b1;
                end
                if (w_tick_rise) begin
                    if (ticks_left > TL_W'(1)) begin
                        w_ticks_nx = ticks_left - 1'b1;
                    end else begin
                        w_ticks_nx = '0;
                        w_state_nx = c_ST_OVER;
                        w_hold_nx  = '0;
                        if (w_score_nx > high_score) begin
                            w_high_nx     = w_score_nx;
                            w_new_high_nx = 1'b1;
                        end
                    end
                end
            end
            c_ST_OVER: begin
                w_ticks_nx = '0;
                if (w_tick_rise) begin
                    if (r_hold == c_HOLD_LAST) begin
                        w_state_nx = c_ST_IDLE;
                        w_hold_nx  = '0;
                    end else begin
                        w_hold_nx = r_hold + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx = c_ST_IDLE;
                w_hold_nx  = '0;
                w_ticks_nx = '0;
            end
        endcase
    end

    // State, edge-detect history and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= c_ST_IDLE;
            r_start_q    <= 1'b1;
            r_hit_q      <= 1'b1;
            r_tick_q     <= 1'b1;
            r_hold       <= '0;
            timer_enable <= 1'b0;
            playing      <= 1'b0;
            game_over    <= 1'b0;
            score        <= '0;
            high_score   <= '0;
            new_high     <= 1'b0;
            ticks_left   <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_start_q    <= start;
            r_hit_q      <= hit;
            r_tick_q     <= timer_tick;
            r_hold       <= w_hold_nx;
            timer_enable <= (w_state_nx != c_ST_IDLE);
            playing      <= (w_state_nx == c_ST_PLAY);
            game_over    <= (w_state_nx == c_ST_OVER);
            score        <= w_score_nx;
            high_score   <= w_high_nx;
            new_high     <= w_new_high_nx;
            ticks_left   <= w_ticks_nx;
        end
    end

endmodule
`default_nettype wire

// File: doc/round_controller.md
Name: round_controller

Overview:
- Game-round sequencer that sits directly downstream of the millisecond timer and consumes its max_reached output as a coarse time tick.
- Arms the timer, runs a fixed-length round measured in timer ticks, counts player hits, ends the round on timeout and tracks a high score.
- Outputs drive the score display and the status LEDs.

Parameters:
- SCORE_W, 8, width of the score and high_score registers.
- TICKS_PER_ROUND, 6, number of timer ticks in one play round. Legal range is 1 or more.
- OVER_HOLD_TICKS, 2, number of ticks spent in OVER before returning to IDLE. Legal range is 1 or more.
- TL_W, $clog2(TICKS_PER_ROUND+1), width of ticks_left (derived; do not override).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  start button, already synchronised and debounced; level signal.
- hit  input  1  player hit button, already synchronised and debounced; level signal.
- timer_tick  input  1  timer max_reached; may stay high for many cycles.
- timer_enable  output  1  enable for the upstream timer.
- playing  output  1  high in state PLAY.
- game_over  output  1  high in state OVER.
- score  output  SCORE_W  hits counted in the current or last round.
- high_score  output  SCORE_W  best score since reset.
- new_high  output  1  one-cycle pulse when high_score is updated.
- ticks_left  output  TL_W  remaining play ticks.

Behaviour:
- Reset (reset=0, asynchronous):
  - state = IDLE.
  - All outputs 0, including high_score.
  - Edge-detect registers: start_q=1, hit_q=1, tick_q=1. This blocks false edges from inputs already high when reset releases.
- Edge detection:
  - start_rise = start & ~start_q; hit_rise and tick_rise are formed the same way.
  - The _q registers update every cycle in every state.
  - An input held high produces exactly one rise.
- All state and outputs are registered. Each response appears on the cycle after the edge is sampled.
- IDLE:
  - timer_enable=0. score holds the last round's value.
  - start_rise: go to READY, score<=0, timer_enable<=1.
- READY (one-tick get-ready period):
  - timer_enable=1. hit_rise is ignored.
  - tick_rise: go to PLAY, ticks_left<=TICKS_PER_ROUND.
- PLAY:
  - timer_enable=1, playing=1.
  - hit_rise: score<=score+1, saturating at 2^SCORE_W-1 with no wrap.
  - tick_rise with ticks_left>1: ticks_left<=ticks_left-1.
  - tick_rise with ticks_left==1: ticks_left<=0 and go to OVER.
  - hit_rise and final tick_rise in the same cycle: the hit is counted, so the final score includes it.
- Entry to OVER:
  - final_score is score plus any same-cycle hit.
  - If final_score > high_score: high_score<=final_score and new_high pulses for exactly 1 cycle.
  - Equal scores do not update high_score.
- OVER:
  - game_over=1, timer_enable=1.
  - An internal hold counter counts tick_rise. After OVER_HOLD_TICKS rises, go to IDLE and set timer_enable<=0.
  - start_rise and hit_rise are ignored.
- start_rise in READY, PLAY or OVER is ignored. There is no restart mid-round.
- Reset asserted mid-round: immediate return to IDLE with everything cleared, high_score included.
- ticks_left reads 0 outside PLAY, except that it holds 0 after a round ends.
- State encoding is implementer's choice. There must be no unreachable lock-up states; any illegal encoding recovers to IDLE.

Test Plan:
- Reset with start=1 held through release -> no transition; state IDLE; all outputs 0.
- TICKS_PER_ROUND=3, OVER_HOLD_TICKS=1:
  - Stimulus: start pulse, 1 tick, 5 hit pulses spread over 3 ticks.
  - Required: READY then PLAY; ticks_left goes 3,2,1,0; score=5; game_over=1; high_score=5; new_high high for 1 cycle; next tick returns to IDLE with timer_enable=0.
- Second round scoring 4, then third round scoring 5:
  - Round 2: high_score stays 5, no new_high.
  - Round 3 (equal score): high_score stays 5, no new_high.
- hit_rise on the same cycle as the final tick with score=2 -> final score 3 and high_score uses 3.
- timer_tick held high for 1000 cycles -> counts as one tick only.
- hit held high across PLAY -> score increments once.
- SCORE_W=3, 9 hits in a round -> score saturates at 7.
- hit pulses during READY and OVER -> score unchanged.
- start during PLAY -> ignored.
- reset pulse mid-PLAY -> IDLE with all outputs 0.
